// File: rtl/load_store_unit_pkg.sv
// Shared types, funct3 encodings and byte-lane datapath helpers for the load/store unit.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT_W = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
    } store_lanes_t;

    // Illegal encodings and misaligned addresses never reach memory.
    function automatic logic req_illegal(input logic we, input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = we;
            F3_H:    bad = addr_lo[0];
            F3_HU:   bad = we | addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic store_lanes_t store_lanes(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                                 input logic [31:0] wdata);
        store_lanes_t lanes;
        case (funct3)
            F3_B: begin
                lanes.mask = 4'b0001 << addr_lo;
                lanes.data = {4{wdata[7:0]}};
            end
            F3_H: begin
                lanes.mask = 4'b0011 << {addr_lo[1], 1'b0};
                lanes.data = {2{wdata[15:0]}};
            end
            F3_W: begin
                lanes.mask = 4'b1111;
                lanes.data = wdata;
            end
            default: begin
                lanes.mask = 4'b0000;
                lanes.data = 32'h0000_0000;
            end
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                                 input logic [31:0] data);
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        logic [31:0] result;
        byte_sel = data[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? data[31:16] : data[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h00_0000, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0000, half_sel};
            F3_W:    result = data;
            default: result = 32'h0000_0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a core request port and a byte-masked shared memory.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int MASK_SIZE = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  write_en,
    output logic                  read_en,
    output logic [MASK_SIZE-1:0]  mask,
    output logic [31:0]           addr,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  w_success,
    input  logic                  r_success
);

    lsu_state_e            state_r;
    lsu_state_e            state_nxt_s;
    logic                  we_r;
    logic [2:0]            funct3_r;
    logic [31:0]           addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  err_r;
    logic                  accept_s;
    logic                  illegal_s;
    store_lanes_t          lanes_s;
    logic                  unused_r_success_s;

    // Loads complete in the access cycle, so the read handshake carries no information.
    assign unused_r_success_s = r_success;
    assign accept_s  = (state_r == ST_IDLE) && req_valid;
    assign illegal_s = req_illegal(req_we, req_funct3, req_addr[1:0]);
    assign lanes_s   = store_lanes(funct3_r, addr_r[1:0], wdata_r);

    // State register and latched request / response fields.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_r  <= ST_IDLE;
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                we_r     <= req_we;
                funct3_r <= req_funct3;
                addr_r   <= req_addr;
                wdata_r  <= req_wdata;
                rdata_r  <= 32'h0000_0000;
                err_r    <= illegal_s;
            end else if ((state_r == ST_ACCESS) && !we_r) begin
                rdata_r <= load_extract(funct3_r, addr_r[1:0], data_out);
            end else if ((state_r == ST_RESP) && resp_ready) begin
                rdata_r <= 32'h0000_0000;
                err_r   <= 1'b0;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = illegal_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_nxt_s = we_r ? ST_WAIT_W : ST_RESP;
            ST_WAIT_W: begin
                if (w_success) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT_W;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Core-side and memory-side outputs; the memory bus is quiet outside ACCESS.
    always_comb begin
        req_ready  = (state_r == ST_IDLE);
        resp_valid = (state_r == ST_RESP);
        resp_rdata = rdata_r;
        resp_err   = err_r;
        read_en    = 1'b0;
        write_en   = 1'b0;
        mask       = '0;
        addr       = 32'h0000_0000;
        data_in    = 32'h0000_0000;
        if (state_r == ST_ACCESS) begin
            addr = addr_r;
            if (we_r) begin
                write_en = 1'b1;
                mask     = lanes_s.mask;
                data_in  = lanes_s.data;
            end else begin
                read_en = 1'b1;
            end
        end else begin
            addr = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit against a small byte-masked memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        write_en;
    logic        read_en;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        w_success = 1'b0;
    logic        r_success;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .write_en(write_en), .read_en(read_en), .mask(mask), .addr(addr),
        .data_in(data_in), .data_out(data_out),
        .w_success(w_success), .r_success(r_success)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255] = '{64: 32'h8899_AABB, default: 32'h0000_0000};
    int          total = 0;
    int          bad = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          w_extra = 0;
    int          wwait = 0;
    bit          wbusy = 1'b0;
    logic [31:0] last_addr = 32'h0;
    logic [3:0]  last_mask = 4'h0;
    logic [31:0] last_din = 32'h0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    assign data_out  = mem[addr[9:2]];
    assign r_success = read_en;

    // Memory model: write applied when write_en is seen, w_success pulses w_extra cycles later.
    always @(negedge clk) begin
        w_success = 1'b0;
        if (wbusy) begin
            if (wwait == 0) begin
                w_success = 1'b1;
                wbusy = 1'b0;
            end else begin
                wwait = wwait - 1;
            end
        end
        if (read_en) begin
            rd_cnt++;
            last_addr = addr;
        end
        if (write_en) begin
            wr_cnt++;
            last_addr = addr;
            last_mask = mask;
            last_din  = data_in;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) mem[addr[9:2]][8*i +: 8] = data_in[8*i +: 8];
            end
            wbusy = 1'b1;
            wwait = w_extra;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'h1);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'h0);
        check({tag, " resp_err"}, 32'(resp_err), 32'h0);
        check({tag, " resp_rdata"}, resp_rdata, 32'h0);
        check({tag, " rd_wr_en"}, {30'h0, read_en, write_en}, 32'h0);
        check({tag, " mask"}, 32'(mask), 32'h0);
        check({tag, " addr"}, addr, 32'h0);
        check({tag, " data_in"}, data_in, 32'h0);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int lat,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_rd, input int exp_wr, input logic [3:0] exp_mask,
                          input logic [31:0] exp_din, input int hold);
        exp_t e;
        int   rd0;
        int   wr0;
        int   n;
        @(negedge clk);
        check({tag, " req_ready"}, 32'(req_ready), 32'h1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = lat;
        sb_q.push_back(e);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        e = sb_q.pop_front();
        check({tag, " latency"}, n, e.lat);
        check({tag, " rdata"}, resp_rdata, e.rdata);
        check({tag, " err"}, 32'(resp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, {30'h0, resp_valid, req_ready}, 32'h2);
            check({tag, " hold rdata"}, resp_rdata, e.rdata);
            check({tag, " hold mem idle"}, {30'h0, read_en, write_en}, 32'h0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, " released"}, {30'h0, resp_valid, req_ready}, 32'h1);
        check({tag, " reads"}, rd_cnt - rd0, exp_rd);
        check({tag, " writes"}, wr_cnt - wr0, exp_wr);
        if (exp_rd + exp_wr != 0) check({tag, " mem addr"}, last_addr, a);
        if (exp_wr != 0) begin
            check({tag, " mask"}, 32'(last_mask), 32'(exp_mask));
            check({tag, " data_in"}, last_din, exp_din);
        end
    endtask

    initial begin
        arst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        arst_n = 1'b1;

        // loads from word 0x100 = 0x8899AABB
        do_req("LB 101",  1'b0, 3'b000, 32'h101, 32'h0, 2, 32'hFFFF_FFAA, 1'b0, 1, 0, 4'h0, 32'h0, 0);
        do_req("LHU 102", 1'b0, 3'b101, 32'h102, 32'h0, 2, 32'h0000_8899, 1'b0, 1, 0, 4'h0, 32'h0, 0);
        do_req("LH 102",  1'b0, 3'b001, 32'h102, 32'h0, 2, 32'hFFFF_8899, 1'b0, 1, 0, 4'h0, 32'h0, 0);
        do_req("LBU 100", 1'b0, 3'b100, 32'h100, 32'h0, 2, 32'h0000_00BB, 1'b0, 1, 0, 4'h0, 32'h0, 0);
        do_req("LB 103",  1'b0, 3'b000, 32'h103, 32'h0, 2, 32'hFFFF_FF88, 1'b0, 1, 0, 4'h0, 32'h0, 0);
        do_req("LW 100",  1'b0, 3'b010, 32'h100, 32'h0, 2, 32'h8899_AABB, 1'b0, 1, 0, 4'h0, 32'h0, 0);

        // stores and read-back
        do_req("SB 203", 1'b1, 3'b000, 32'h203, 32'h1234_5678, 3, 32'h0, 1'b0, 0, 1, 4'b1000, 32'h7878_7878, 0);
        do_req("LW 200a", 1'b0, 3'b010, 32'h200, 32'h0, 2, 32'h7800_0000, 1'b0, 1, 0, 4'h0, 32'h0, 0);
        do_req("SH 200", 1'b1, 3'b001, 32'h200, 32'hCAFE_BEEF, 3, 32'h0, 1'b0, 0, 1, 4'b0011, 32'hBEEF_BEEF, 0);
        do_req("SH 202", 1'b1, 3'b001, 32'h202, 32'h0000_1234, 3, 32'h0, 1'b0, 0, 1, 4'b1100, 32'h1234_1234, 0);
        do_req("LW 200b", 1'b0, 3'b010, 32'h200, 32'h0, 2, 32'h1234_BEEF, 1'b0, 1, 0, 4'h0, 32'h0, 0);
        do_req("LHU 200", 1'b0, 3'b101, 32'h200, 32'h0, 2, 32'h0000_BEEF, 1'b0, 1, 0, 4'h0, 32'h0, 0);
        do_req("SW 204", 1'b1, 3'b010, 32'h204, 32'hDEAD_BEEF, 3, 32'h0, 1'b0, 0, 1, 4'b1111, 32'hDEAD_BEEF, 0);
        do_req("LW 204", 1'b0, 3'b010, 32'h204, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1, 0, 4'h0, 32'h0, 0);

        // illegal encodings and misaligned accesses
        do_req("LW mis",  1'b0, 3'b010, 32'h102, 32'h0, 1, 32'h0, 1'b1, 0, 0, 4'h0, 32'h0, 0);
        do_req("S f3 101", 1'b1, 3'b101, 32'h200, 32'h5555, 1, 32'h0, 1'b1, 0, 0, 4'h0, 32'h0, 0);
        do_req("S f3 100", 1'b1, 3'b100, 32'h200, 32'h55, 1, 32'h0, 1'b1, 0, 0, 4'h0, 32'h0, 0);
        do_req("L f3 011", 1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 1'b1, 0, 0, 4'h0, 32'h0, 0);
        do_req("L f3 111", 1'b0, 3'b111, 32'h100, 32'h0, 1, 32'h0, 1'b1, 0, 0, 4'h0, 32'h0, 0);
        do_req("LH mis",  1'b0, 3'b001, 32'h101, 32'h0, 1, 32'h0, 1'b1, 0, 0, 4'h0, 32'h0, 0);
        do_req("SW mis",  1'b1, 3'b010, 32'h202, 32'h1, 1, 32'h0, 1'b1, 0, 0, 4'h0, 32'h0, 0);

        // response held by a stalled core, then a slow memory write
        do_req("LB hold", 1'b0, 3'b000, 32'h101, 32'h0, 2, 32'hFFFF_FFAA, 1'b0, 1, 0, 4'h0, 32'h0, 5);
        w_extra = 2;
        do_req("SB slow", 1'b1, 3'b000, 32'h206, 32'h0000_00A5, 5, 32'h0, 1'b0, 0, 1, 4'b0100, 32'hA5A5_A5A5, 0);
        w_extra = 0;
        do_req("LW 204b", 1'b0, 3'b010, 32'h204, 32'h0, 2, 32'hDEA5_BEEF, 1'b0, 1, 0, 4'h0, 32'h0, 0);

        // reset pulse while a store waits for w_success
        w_extra = 3;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h208; req_wdata = 32'h1111_1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        @(negedge clk);
        check("rst store access", {30'h0, read_en, write_en}, 32'h1);
        @(negedge clk);
        check("rst store wait", {30'h0, resp_valid, req_ready}, 32'h0);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        check_reset_outputs("rst wait_w");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst no resp", {30'h0, resp_valid, req_ready}, 32'h1);
        end
        w_extra = 0;
        check("rst write done", mem[8'h82], 32'h1111_1111);
        do_req("LW 208", 1'b0, 3'b010, 32'h208, 32'h0, 2, 32'h1111_1111, 1'b0, 1, 0, 4'h0, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
